// File: rtl/sipo_buffer.sv
// sipo_buffer: assembles K = N/M serial M-bit words into one N-bit block, first word in the MSBs.
// Defining SIPO_BUFFER_OVERRUN_FLAG_EN adds a sticky overrun output.
module sipo_buffer #(
    parameter int N = 1344,
    parameter int M = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
    ,
    output logic         overrun
`endif
);
    localparam int K  = N / M;
    localparam int CW = $clog2(K + 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  data_q;
    logic [N-1:0]  data_d;
    logic          accept;

    // A held block frees its slot in the same cycle it is taken, so the upstream sees no bubble.
    assign in_ready  = (state_q == FILL) || out_ready;
    assign accept    = in_valid && in_ready;
    assign data_d    = {data_q[N-M-1:0], in_data};
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (clear) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else if (accept) begin
            data_q <= data_d;
            if (state_q == FULL) begin
                state_q <= FILL;
                cnt_q   <= CW'(1);
            end else if (cnt_q == CW'(K - 1)) begin
                state_q <= FULL;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (state_q == FULL && out_ready) begin
            state_q <= FILL;
        end
    end

`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (clear) begin
            overrun_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif
endmodule

// File: tb/tb_sipo_buffer.sv
// tb_sipo_buffer: directed and randomised-stall checks of sipo_buffer at N=1344, M=64.
module tb_sipo_buffer;
    localparam int N = 1344;
    localparam int M = 64;
    localparam int K = N / M;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
    logic         overrun;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sipo_buffer #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
        ,
        .overrun  (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [M-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [M-1:0] word_of(input logic [N-1:0] blk, input int i);
        return blk[M*(K-1-i) +: M];
    endfunction

    // Sends K words base..base+K-1 and checks out_valid rises exactly on the last one.
    task automatic fill_block(input string tag, input logic [M-1:0] base);
        for (int i = 0; i < K; i++) begin
            send(base + M'(i));
            if (i == K - 2) chk({tag, "_notyet"}, 64'(out_valid), 64'd0);
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_first"}, word_of(out_data, 0), base);
        chk({tag, "_last"}, word_of(out_data, K - 1), base + M'(K - 1));
    endtask

    task automatic release_block;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [N-1:0] exp_q[$];
    logic [N-1:0] acc;
    logic [N-1:0] eb;
    int wc;
    int blocks;
    int cycles;

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data_hi", word_of(out_data, 0), 64'd0);
        chk("rst_data_lo", word_of(out_data, K - 1), 64'd0);
`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
        chk("rst_overrun", 64'(overrun), 64'd0);
`endif
        #7 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back fill of words 0..20 with the consumer stalled.
        fill_block("b2b", 64'd0);
        chk("b2b_mid", word_of(out_data, 10), 64'd10);
        chk("b2b_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 64'hFFFF;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_lo", word_of(out_data, K - 1), 64'd20);
        chk("hold_hi", word_of(out_data, 0), 64'd0);
`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
        chk("ovr_set", 64'(overrun), 64'd1);
        repeat (2) tick();
        chk("ovr_sticky", 64'(overrun), 64'd1);
`endif

        // Release with a word offered in the same cycle: it becomes word 1 of the next block.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hAA;
        #1;
        chk("pass_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pass_valid", 64'(out_valid), 64'd0);
        chk("pass_lo", word_of(out_data, K - 1), 64'hAA);
        for (int i = 1; i < K; i++) begin
            send(64'd100 + 64'(i));
            if (i == K - 2) chk("pass_notyet", 64'(out_valid), 64'd0);
        end
        chk("pass_full", 64'(out_valid), 64'd1);
        chk("pass_first", word_of(out_data, 0), 64'hAA);
        chk("pass_last", word_of(out_data, K - 1), 64'd120);
        release_block();
        chk("rel_valid", 64'(out_valid), 64'd0);

        // Clear after ten words drops both the partial block and the offered word.
        for (int i = 0; i < 10; i++) send(64'd200 + 64'(i));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
`ifdef SIPO_BUFFER_OVERRUN_FLAG_EN
        chk("clr_overrun", 64'(overrun), 64'd0);
`endif
        fill_block("clr", 64'd300);
        release_block();

        // Asynchronous reset between edges while word 15 is on the bus.
        for (int i = 0; i < 14; i++) send(64'd400 + 64'(i));
        in_valid = 1'b1;
        in_data  = 64'd414;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_hi", word_of(out_data, 0), 64'd0);
        chk("arst_lo", word_of(out_data, K - 1), 64'd0);
        chk("arst_all", 64'(out_data == '0), 64'd1);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        fill_block("arst", 64'd500);
        release_block();

        // Random stalls on both sides over 100 blocks against a word-level scoreboard.
        acc = '0;
        wc = 0;
        blocks = 0;
        cycles = 0;
        while (blocks < 100 && cycles < 20000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(1) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    eb = exp_q.pop_front();
                    chk("rnd_hi", word_of(out_data, 0), word_of(eb, 0));
                    chk("rnd_blk", 64'(out_data == eb), 64'd1);
                end
                blocks++;
            end
            if (in_valid && in_ready) begin
                acc = {acc[N-M-1:0], in_data};
                wc++;
                if (wc == K) begin
                    exp_q.push_back(acc);
                    wc = 0;
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_blocks", 64'(blocks), 64'd100);
        chk("rnd_leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sipo_buffer.md
SIPO_BUFFER -- requirements
Module: sipo_buffer

Interface
REQ-001 Parameter N, default 1344, is the output block width in bits.
REQ-002 Parameter M, default 64, is the input word width in bits; N SHALL be an integer multiple of M, and K = N/M (default 21).
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 clear  input  1  is a synchronous discard of any partial or complete block.
REQ-006 in_valid  input  1  means in_data holds a valid word.
REQ-007 in_ready  output  1  means the block accepts a word this cycle.
REQ-008 in_data  input  M  is the serial input word.
REQ-009 out_valid  output  1  means out_data holds a complete block.
REQ-010 out_ready  input  1  means the consumer takes the block this cycle.
REQ-011 out_data  output  N  is the assembled parallel block.

Function
REQ-012 An input word SHALL be accepted only on a clock edge where in_valid=1 and in_ready=1.
REQ-013 Each accepted word SHALL shift the N-bit register left by M, with in_data entering bits [M-1:0].
REQ-014 The first accepted word of a block SHALL end up in out_data[N-1:N-M], and the K-th word in out_data[M-1:0].
REQ-015 Word counter cnt SHALL have width clog2(K+1), range 0..K-1 in state FILL, and be reset to 0.
REQ-016 The FSM SHALL have two states, FILL (collecting) and FULL (block held, out_valid=1).
REQ-017 In FILL, in_ready=1; on an accept with cnt=K-1 the FSM SHALL go to FULL and reset cnt to 0; otherwise cnt increments.
REQ-018 In FULL, out_data and out_valid SHALL remain stable until out_ready=1.
REQ-019 In FULL, in_ready SHALL equal out_ready (combinational pass-through, no bubble).
REQ-020 In FULL with out_ready=1 and in_valid=0, the FSM SHALL go to FILL with cnt=0.
REQ-021 In FULL with out_ready=1 and in_valid=1, the block SHALL be released and the word accepted as word 1 of the next block (FILL, cnt=1).
REQ-022 Latency: out_valid SHALL rise on the edge that accepts word K, i.e. it is visible the cycle after that acceptance.
REQ-023 Maximum throughput SHALL be one word per cycle sustained, so one block every K cycles.
REQ-024 When clear=1, the block SHALL go to FILL with cnt=0 and out_valid=0, with clear taking priority over any handshake in that cycle; a word offered that cycle is dropped.
REQ-025 out_data content after clear is don't-care until the next block completes.

Reset
REQ-026 When rst_n=0, the block SHALL immediately force state FILL, cnt=0, out_valid=0 and out_data=0, regardless of clk.
REQ-027 Reset release mid-block SHALL discard all partial data; the first accepted word after release becomes word 1.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is deasserted.

Configuration
REQ-029 The macro SIPO_BUFFER_OVERRUN_FLAG_EN SHALL control an overrun flag.
REQ-030 With the macro defined, an extra output overrun (1 bit) SHALL be added; it is set when in_valid=1 and in_ready=0, is sticky, and is cleared only by rst_n or clear.
REQ-031 With the macro undefined, the overrun port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-032 Reset, then 21 back-to-back words 0..20 with out_ready=0 -> out_valid=1 one cycle after word 20 is accepted, out_data[1343:1280]=0, out_data[63:0]=20, in_ready=0.
REQ-033 Full block held, out_ready=1 with in_valid=1 and data 0xAA -> block released that cycle, cnt=1, out_valid=0 next cycle, 0xAA is word 1 of the next block.
REQ-034 Ten words accepted, then clear=1 with in_valid=1 -> cnt=0, out_valid=0, the offered word is dropped, and the next block needs 21 fresh words.
REQ-035 rst_n pulsed low asynchronously between edges during word 15 -> out_valid=0 and out_data=0 immediately; 21 new words are needed after release.
REQ-036 Random in_valid/out_ready stalls over 100 blocks -> each out_data equals the concatenation of its 21 accepted words, MSB chunk first, with no loss or duplication.
REQ-037 With SIPO_BUFFER_OVERRUN_FLAG_EN defined: full block, out_ready=0, in_valid=1 -> overrun=1 and stays 1 until clear=1, then returns to 0.
